stopwatch_ctrl: RTL and testbench
=================================

# stopwatch_ctrl

Control sequencer for the single-digit stopwatch datapath. It synchronizes and debounces the raw push-buttons, turns each press into a one-cycle command, and runs the stopwatch state machine. It also generates the one-second count-enable tick from the 50 MHz clock, plus the clear and lap-capture strobes that drive the BCD counter and display mux. The counter and 7-segment decoder consume its outputs directly; it contains no count storage itself.

## Interface
- DEBOUNCE_CYCLES, 1_000_000, consecutive stable samples needed to accept a button level change (20 ms at 50 MHz); legal range ≥1
- TICK_DIV, 50_000_000, clk_50mhz cycles per tick; legal range ≥2; prescaler width is $clog2(TICK_DIV)
- clk_50mhz  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- btn_start  in  1  raw asynchronous button, active-high
- btn_stop  in  1  raw asynchronous button, active-high
- btn_clear  in  1  raw asynchronous button, active-high
- btn_lap  in  1  raw asynchronous button, active-high
- tick  out  1  one-cycle count-enable pulse for the datapath counter
- clear  out  1  one-cycle counter clear strobe
- lap_capture  out  1  one-cycle strobe that latches the lap register
- show_lap  out  1  display mux select: 1 = latched lap value, 0 = live count
- state  out  2  current FSM state, encoded as below

## Operation
- Per-button input path:
  - 2-flop synchronizer feeds the debouncer.
  - The debouncer keeps a stable level `deb` and a counter.
  - When sync ≠ deb, the counter increments. When it reaches DEBOUNCE_CYCLES−1 while still ≠, `deb` takes the sync value and the counter returns to 0.
  - When sync = deb, the counter clears to 0.
  - A press pulse is the registered rising edge of `deb`: one cycle per press, however long the button is held.
- Simultaneous press pulses resolve by priority: clear > stop > start > lap. Only the winner acts.
- State encoding: IDLE=00, RUNNING=01, PAUSED=10, LAP=11.
- IDLE:
  - start → RUNNING.
  - clear → stays IDLE and emits a clear pulse.
- RUNNING:
  - stop → PAUSED.
  - lap → LAP and emits a lap_capture pulse.
  - clear → IDLE and emits a clear pulse.
- LAP:
  - lap → RUNNING.
  - stop → PAUSED.
  - clear → IDLE and emits a clear pulse.
- PAUSED:
  - start → RUNNING.
  - clear → IDLE and emits a clear pulse.
- Any press not listed for the current state is ignored.
- Prescaler behaviour by state:
  - Counts 0..TICK_DIV−1 only in RUNNING or LAP.
  - tick=1 in the cycle the prescaler holds TICK_DIV−1; it then wraps to 0.
  - Holds its value in PAUSED, so a resume completes the partial second.
  - Forced to 0 in IDLE and on any clear.
- show_lap = 1 exactly while state = LAP. Ticks continue in LAP.
- All outputs are registered.

## Timing
- Reset values, effective at the next edge:
  - state=00; tick, clear, lap_capture, show_lap = 0.
  - Prescaler = 0.
  - Synchronizers, deb and debounce counters = 0.
- Reset mid-operation aborts any pending debounce or running second. A button still held after reset is released must complete a full debounce before it acts.
- Press latency: take the first edge sampling the raw button high as edge 0, with the input stable from then on.
  - deb rises at edge DEBOUNCE_CYCLES+1.
  - The press pulse is high in the following cycle.
  - state, clear, lap_capture and show_lap update at edge DEBOUNCE_CYCLES+2.
- First tick after entering RUNNING from IDLE occurs in the TICK_DIV-th RUNNING cycle. Period thereafter is TICK_DIV cycles.
- A glitch shorter than DEBOUNCE_CYCLES stable samples produces no press. Bounce restarts the count.
- clear and lap_capture never assert in the same cycle. tick never asserts in a cycle where clear asserts.

## Configuration
- STOPWATCH_CTRL_LAP_EN defined:
  - Lap feature is present exactly as described: btn_lap debouncer, LAP state, lap_capture and show_lap.
- STOPWATCH_CTRL_LAP_EN undefined:
  - btn_lap port remains but is unused; no debouncer is built for it.
  - lap_capture and show_lap are tied to 0.
  - State 11 is unreachable; in RUNNING a lap press is ignored.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and TICK_DIV=10.
- Reset, then btn_start held 20 cycles from edge 0 → state 00→01 at edge 6, one press only; tick in the 10th RUNNING cycle and every 10 cycles after.
- btn_start toggling every 2 cycles for 12 cycles, then low → state stays 00; tick, clear and lap_capture never assert.
- Run 15 RUNNING cycles (1 tick), stop, wait 50 cycles, start → no tick while PAUSED; the first tick after resume comes in the 5th RUNNING cycle.
- In RUNNING, btn_start and btn_clear rise on the same edge → state 00 and one clear pulse at edge 6; no further ticks; prescaler restarts from 0 on the next start.
- With STOPWATCH_CTRL_LAP_EN, lap press in RUNNING:
  - state 11, lap_capture for 1 cycle, show_lap=1, ticks continue.
  - Second lap press → state 01, show_lap=0.
  - Without the macro the same stimulus leaves state 01 and both outputs 0.
- Assert reset in RUNNING mid-second while btn_stop is mid-debounce → all outputs 0 and state 00 the next edge. After release, the still-held btn_stop causes no transition (stop is ignored in IDLE). A start press then needs the full 6-edge latency.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - stopwatch button conditioning, state machine and one-second tick; lap feature under STOPWATCH_CTRL_LAP_EN

// Button conditioner: 2-flop synchronizer, counting debouncer, press on rising edge of the debounced level.
module stopwatch_ctrl_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk_50mhz,
    input  logic reset,
    input  logic btn,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_1;
    logic             sync_2;
    logic             deb;
    logic             deb_d;
    logic [CNT_W-1:0] cnt;

    // Synchronize the raw level, then accept a change only after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clk_50mhz) begin
        if (reset) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            deb    <= 1'b0;
            deb_d  <= 1'b0;
            cnt    <= '0;
        end else begin
            sync_1 <= btn;
            sync_2 <= sync_1;
            deb_d  <= deb;
            if (sync_2 != deb) begin
                if (cnt == CNT_LAST) begin
                    deb <= sync_2;
                    cnt <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    // One pulse per accepted press, built only from registered levels.
    assign press = deb & ~deb_d;

endmodule

// Stopwatch sequencer: turns conditioned button presses into state changes and datapath strobes.
module stopwatch_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int TICK_DIV        = 50_000_000
) (
    input  logic       clk_50mhz,
    input  logic       reset,
    input  logic       btn_start,
    input  logic       btn_stop,
    input  logic       btn_clear,
    input  logic       btn_lap,
    output logic       tick,
    output logic       clear,
    output logic       lap_capture,
    output logic       show_lap,
    output logic [1:0] state
);

    localparam int PRESC_W = $clog2(TICK_DIV);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RUNNING = 2'b01,
        ST_PAUSED  = 2'b10,
        ST_LAP     = 2'b11
    } state_t;

    state_t             state_q;
    state_t             state_next;
    logic [PRESC_W-1:0] presc;
    logic [PRESC_W-1:0] presc_next;
    logic               tick_next;
    logic               clear_next;
    logic               lap_next;

    logic press_start;
    logic press_stop;
    logic press_clear;
    logic press_lap;
    logic cmd_start;
    logic cmd_stop;
    logic cmd_clear;
    logic cmd_lap;

    stopwatch_ctrl_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_start (
        .clk_50mhz (clk_50mhz),
        .reset     (reset),
        .btn       (btn_start),
        .press     (press_start)
    );

    stopwatch_ctrl_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_stop (
        .clk_50mhz (clk_50mhz),
        .reset     (reset),
        .btn       (btn_stop),
        .press     (press_stop)
    );

    stopwatch_ctrl_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_clear (
        .clk_50mhz (clk_50mhz),
        .reset     (reset),
        .btn       (btn_clear),
        .press     (press_clear)
    );

`ifdef STOPWATCH_CTRL_LAP_EN
    stopwatch_ctrl_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_lap (
        .clk_50mhz (clk_50mhz),
        .reset     (reset),
        .btn       (btn_lap),
        .press     (press_lap)
    );
`else
    assign press_lap = 1'b0;
`endif

    // Only the highest-priority press of a cycle is allowed to act: clear > stop > start > lap.
    always_comb begin
        cmd_clear = press_clear;
        cmd_stop  = press_stop  & ~press_clear;
        cmd_start = press_start & ~press_stop & ~press_clear;
        cmd_lap   = press_lap   & ~press_start & ~press_stop & ~press_clear;
    end

    // State register plus the registered strobes that leave the block.
    always_ff @(posedge clk_50mhz) begin
        if (reset) begin
            state_q <= ST_IDLE;
            presc   <= '0;
            tick    <= 1'b0;
            clear   <= 1'b0;
        end else begin
            state_q <= state_next;
            presc   <= presc_next;
            tick    <= tick_next;
            clear   <= clear_next;
        end
    end

    // Next-state and strobe decode; presses not meaningful in the current state fall through unchanged.
    always_comb begin
        state_next = state_q;
        clear_next = 1'b0;
        lap_next   = 1'b0;
        if (cmd_clear) begin
            state_next = ST_IDLE;
            clear_next = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_start) state_next = ST_RUNNING;
                end
                ST_RUNNING: begin
                    if (cmd_stop) begin
                        state_next = ST_PAUSED;
                    end else if (cmd_lap) begin
                        state_next = ST_LAP;
                        lap_next   = 1'b1;
                    end
                end
                ST_LAP: begin
                    if (cmd_stop)     state_next = ST_PAUSED;
                    else if (cmd_lap) state_next = ST_RUNNING;
                end
                ST_PAUSED: begin
                    if (cmd_start) state_next = ST_RUNNING;
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // Prescaler advances on cycles spent counting, holds while paused, and restarts whenever the watch goes idle.
    always_comb begin
        presc_next = presc;
        tick_next  = 1'b0;
        if (state_next == ST_IDLE) begin
            presc_next = '0;
        end else if (state_q == ST_RUNNING || state_q == ST_LAP) begin
            presc_next = (presc == PRESC_LAST) ? '0 : presc + PRESC_W'(1);
        end
        tick_next = (state_next == ST_RUNNING || state_next == ST_LAP) && (presc_next == PRESC_LAST);
    end

`ifdef STOPWATCH_CTRL_LAP_EN
    // Lap strobe and display select follow the decoded next state.
    always_ff @(posedge clk_50mhz) begin
        if (reset) begin
            lap_capture <= 1'b0;
            show_lap    <= 1'b0;
        end else begin
            lap_capture <= lap_next;
            show_lap    <= (state_next == ST_LAP);
        end
    end
`else
    logic unused_lap;
    assign unused_lap  = btn_lap | lap_next;
    assign lap_capture = 1'b0;
    assign show_lap    = 1'b0;
`endif

    assign state = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - directed and random checks of stopwatch_ctrl against a reference model

module tb_stopwatch_ctrl;

    localparam int DEB = 4;
    localparam int TD  = 10;
`ifdef STOPWATCH_CTRL_LAP_EN
    localparam bit LAP_EN = 1'b1;
`else
    localparam bit LAP_EN = 1'b0;
`endif

    localparam int S_IDLE = 0;
    localparam int S_RUN  = 1;
    localparam int S_PAUS = 2;
    localparam int S_LAP  = 3;

    logic       clk_50mhz = 1'b0;
    logic       reset     = 1'b1;
    logic       btn_start = 1'b0;
    logic       btn_stop  = 1'b0;
    logic       btn_clear = 1'b0;
    logic       btn_lap   = 1'b0;
    logic       tick;
    logic       clear;
    logic       lap_capture;
    logic       show_lap;
    logic [1:0] state;

    stopwatch_ctrl #(.DEBOUNCE_CYCLES(DEB), .TICK_DIV(TD)) dut (
        .clk_50mhz   (clk_50mhz),
        .reset       (reset),
        .btn_start   (btn_start),
        .btn_stop    (btn_stop),
        .btn_clear   (btn_clear),
        .btn_lap     (btn_lap),
        .tick        (tick),
        .clear       (clear),
        .lap_capture (lap_capture),
        .show_lap    (show_lap),
        .state       (state)
    );

    always #10 clk_50mhz = ~clk_50mhz;

    int checks   = 0;
    int failures = 0;

    // Reference model: buttons indexed start=0 stop=1 clear=2 lap=3.
    int m_state = S_IDLE;
    int m_phase = 0;
    bit m_deb[4];
    bit m_deb_prev[4];
    bit raw_h0[4];
    bit raw_h1[4];
    bit win[4][$];
    bit e_tick, e_clear, e_lap, e_show;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit raw[4];
        bit press[4];
        int cmd;
        int ns;
        raw = '{btn_start, btn_stop, btn_clear, btn_lap};
        if (reset) begin
            m_state = S_IDLE;
            m_phase = 0;
            for (int b = 0; b < 4; b++) begin
                m_deb[b] = 0; m_deb_prev[b] = 0; raw_h0[b] = 0; raw_h1[b] = 0;
                win[b].delete();
            end
            e_tick = 0; e_clear = 0; e_lap = 0; e_show = 0;
            return;
        end
        for (int b = 0; b < 4; b++) press[b] = m_deb[b] && !m_deb_prev[b];
        if (!LAP_EN) press[3] = 0;
        // debounced level flips once the last DEB synchronized samples all disagree with it
        for (int b = 0; b < 4; b++) begin
            bit s;
            bit all_opp;
            s = raw_h1[b];
            raw_h1[b] = raw_h0[b];
            raw_h0[b] = raw[b];
            win[b].push_back(s);
            if (win[b].size() > DEB) void'(win[b].pop_front());
            m_deb_prev[b] = m_deb[b];
            if (win[b].size() == DEB) begin
                all_opp = 1;
                for (int k = 0; k < win[b].size(); k++) if (win[b][k] == m_deb[b]) all_opp = 0;
                if (all_opp) m_deb[b] = !m_deb[b];
            end
        end
        cmd = press[2] ? 2 : press[1] ? 1 : press[0] ? 0 : press[3] ? 3 : -1;
        ns = m_state;
        e_clear = 0;
        e_lap = 0;
        if (cmd == 2) begin
            ns = S_IDLE;
            e_clear = 1;
        end else if (cmd == 0 && (m_state == S_IDLE || m_state == S_PAUS)) begin
            ns = S_RUN;
        end else if (cmd == 1 && (m_state == S_RUN || m_state == S_LAP)) begin
            ns = S_PAUS;
        end else if (cmd == 3 && m_state == S_RUN) begin
            ns = S_LAP;
            e_lap = 1;
        end else if (cmd == 3 && m_state == S_LAP) begin
            ns = S_RUN;
        end
        if (ns == S_IDLE) m_phase = 0;
        else if (m_state == S_RUN || m_state == S_LAP) m_phase = (m_phase + 1) % TD;
        e_tick = (ns == S_RUN || ns == S_LAP) && (m_phase == TD - 1);
        e_show = (ns == S_LAP);
        m_state = ns;
    endtask

    task automatic step();
        @(posedge clk_50mhz);
        #1;
        model_edge();
        check("cycle", {2'b00, tick, clear, lap_capture, show_lap, state},
              {2'b00, e_tick, e_clear, e_lap, e_show, 2'(m_state)});
    endtask

    function automatic bit in_rng(input int e, input int lo, input int hi);
        return (e >= lo) && (e < hi);
    endfunction

    int hold[5];

    initial begin
        reset = 1'b1;
        step();
        check("reset_outputs", {3'b000, tick, clear, lap_capture, show_lap, state}, 8'h00);
        step();
        reset = 1'b0;

        // bouncing start button: runs of 2 samples never qualify
        for (int i = 0; i < 12; i++) begin
            btn_start = ((i / 2) % 2) == 0;
            step();
            check("bounce_state", {6'b0, state}, 8'h00);
        end
        btn_start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            check("bounce_quiet", {5'b0, tick, clear, lap_capture}, 8'h00);
        end

        // directed timeline; e is the edge index where btn_start is first sampled high
        for (int e = 0; e < 200; e++) begin
            btn_start = in_rng(e, 0, 20) || in_rng(e, 65, 71) || in_rng(e, 90, 100) ||
                        in_rng(e, 110, 118) || in_rng(e, 185, 195);
            btn_stop  = in_rng(e, 15, 23) || in_rng(e, 160, 176);
            btn_clear = in_rng(e, 90, 100);
            btn_lap   = in_rng(e, 130, 140) || in_rng(e, 150, 158);
            reset     = in_rng(e, 163, 165);
            step();
            case (e)
                5:   check("start_latency_pre", {6'b0, state}, 8'h00);
                6:   check("start_latency", {6'b0, state}, 8'h01);
                14:  check("tick_not_early", {7'b0, tick}, 8'h00);
                15:  check("first_tick", {7'b0, tick}, 8'h01);
                20:  check("still_running", {6'b0, state}, 8'h01);
                21:  check("paused", {6'b0, state}, 8'h02);
                25:  check("paused_no_tick", {7'b0, tick}, 8'h00);
                71:  check("resumed", {6'b0, state}, 8'h01);
                74:  check("resume_tick_pre", {7'b0, tick}, 8'h00);
                75:  check("resume_tick", {7'b0, tick}, 8'h01);
                85:  check("resume_tick2", {7'b0, tick}, 8'h01);
                95:  check("tick_before_clear", {7'b0, tick}, 8'h01);
                96: begin
                    check("clear_wins_state", {6'b0, state}, 8'h00);
                    check("clear_pulse", {7'b0, clear}, 8'h01);
                end
                97:  check("clear_one_cycle", {7'b0, clear}, 8'h00);
                105: check("idle_no_tick", {7'b0, tick}, 8'h00);
                116: check("restart_run", {6'b0, state}, 8'h01);
                124: check("restart_tick_pre", {7'b0, tick}, 8'h00);
                125: check("restart_tick", {7'b0, tick}, 8'h01);
                136: begin
                    check("lap_state", {6'b0, state}, LAP_EN ? 8'h03 : 8'h01);
                    check("lap_capture", {7'b0, lap_capture}, {7'b0, LAP_EN});
                    check("lap_show", {7'b0, show_lap}, {7'b0, LAP_EN});
                end
                137: check("lap_capture_one_cycle", {7'b0, lap_capture}, 8'h00);
                145: check("tick_in_lap", {7'b0, tick}, 8'h01);
                156: begin
                    check("lap_exit_state", {6'b0, state}, 8'h01);
                    check("lap_exit_show", {7'b0, show_lap}, 8'h00);
                end
                163: check("reset_mid_run", {3'b0, tick, clear, lap_capture, show_lap, state}, 8'h00);
                172: check("held_stop_ignored", {6'b0, state}, 8'h00);
                184: check("idle_after_reset", {6'b0, state}, 8'h00);
                190: check("post_reset_latency_pre", {6'b0, state}, 8'h00);
                191: check("post_reset_latency", {6'b0, state}, 8'h01);
                default: ;
            endcase
        end

        // random button activity with occasional resets, every cycle compared to the model
        for (int b = 0; b < 5; b++) hold[b] = 0;
        btn_start = 0; btn_stop = 0; btn_clear = 0; btn_lap = 0; reset = 0;
        for (int i = 0; i < 800; i++) begin
            for (int b = 0; b < 4; b++) begin
                if (hold[b] == 0) begin
                    bit lvl;
                    lvl = (b == 2) ? ($urandom_range(0, 3) == 0) : $urandom_range(0, 1) == 1;
                    hold[b] = $urandom_range(1, 14);
                    case (b)
                        0: btn_start = lvl;
                        1: btn_stop  = lvl;
                        2: btn_clear = lvl;
                        default: btn_lap = lvl;
                    endcase
                end else begin
                    hold[b]--;
                end
            end
            reset = ($urandom_range(0, 249) == 0);
            step();
        end
        reset = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
